// File: rtl/and3_coinc_pkg.sv
// Shared encodings and widths for the AND3 coincidence filter.
package and3_coinc_pkg;

    // Width of the run counter behind the ARMING and RELEASING states.
    localparam int RUN_W = 8;

    // Bit 1 of the encoding equals the filtered output level.
    typedef enum logic [1:0] {
        IDLE      = 2'b00,
        ARMING    = 2'b01,
        ACTIVE    = 2'b11,
        RELEASING = 2'b10
    } state_t;

endpackage

// File: rtl/and3_coinc_filt_sat_counter.sv
// Saturating event counter with a sticky overflow flag.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         CK,
    input  logic         RSTN,
    input  logic         CLR,
    input  logic         INC,
    output logic [W-1:0] Q,
    output logic         OVF
);

    // Reset beats clear, clear beats increment; at all-ones the count holds and OVF latches.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            Q   <= '0;
            OVF <= 1'b0;
        end else if (CLR) begin
            Q   <= '0;
            OVF <= 1'b0;
        end else if (INC) begin
            if (&Q) begin
                OVF <= 1'b1;
            end else begin
                Q <= Q + W'(1);
            end
        end
    end

endmodule

// File: rtl/and3_coinc_filt.sv
// Debounces the AND3 product A&B&C into a clean level Z, with a rise pulse
// and a saturating count of rises.
import and3_coinc_pkg::*;

module and3_coinc_filt #(
    parameter int ON_CNT  = 4,
    parameter int OFF_CNT = 2,
    parameter int CNT_W   = 8
) (
    input  logic             CK,
    input  logic             RSTN,
    input  logic             CE,
    input  logic             A,
    input  logic             B,
    input  logic             C,
    input  logic             CLR,
    output logic             Z,
    output logic             ZP,
    output logic [CNT_W-1:0] EVCNT,
    output logic             OVF
);

    localparam logic [RUN_W-1:0] ON_V  = RUN_W'(ON_CNT);
    localparam logic [RUN_W-1:0] OFF_V = RUN_W'(OFF_CNT);
    localparam logic [RUN_W-1:0] ONE_V = RUN_W'(1);

    state_t           state;
    logic [RUN_W-1:0] run;
    logic [RUN_W-1:0] run_inc;
    logic             x;
    logic             rise;

    assign x       = A & B & C;
    assign run_inc = run + ONE_V;

    // Rise: this enabled edge takes the FSM from IDLE/ARMING into ACTIVE.
    always_comb begin
        rise = 1'b0;
        if (CE && x) begin
            case (state)
                IDLE:    rise = (ON_V == ONE_V);
                ARMING:  rise = (run_inc == ON_V);
                default: rise = 1'b0;
            endcase
        end
    end

    // Filter FSM with run counter; Z and ZP are registered alongside the state.
    always_ff @(posedge CK) begin
        if (!RSTN) begin
            state <= IDLE;
            run   <= '0;
            Z     <= 1'b0;
            ZP    <= 1'b0;
        end else begin
            ZP <= rise;
            if (CE) begin
                case (state)
                    IDLE: begin
                        if (x) begin
                            if (ON_V == ONE_V) begin
                                state <= ACTIVE;
                                Z     <= 1'b1;
                            end else begin
                                state <= ARMING;
                                run   <= ONE_V;
                            end
                        end
                    end
                    ARMING: begin
                        if (!x) begin
                            state <= IDLE;
                            run   <= '0;
                        end else if (rise) begin
                            state <= ACTIVE;
                            Z     <= 1'b1;
                            run   <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    ACTIVE: begin
                        if (!x) begin
                            if (OFF_V == ONE_V) begin
                                state <= IDLE;
                                Z     <= 1'b0;
                            end else begin
                                state <= RELEASING;
                                run   <= ONE_V;
                            end
                        end
                    end
                    RELEASING: begin
                        // A single hit cancels the release without a new rise.
                        if (x) begin
                            state <= ACTIVE;
                            run   <= '0;
                        end else if (run_inc == OFF_V) begin
                            state <= IDLE;
                            Z     <= 1'b0;
                            run   <= '0;
                        end else begin
                            run <= run_inc;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        Z     <= 1'b0;
                        run   <= '0;
                    end
                endcase
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_evcnt (
        .CK   (CK),
        .RSTN (RSTN),
        .CLR  (CLR),
        .INC  (rise),
        .Q    (EVCNT),
        .OVF  (OVF)
    );

endmodule

// File: tb/tb_and3_coinc_filt.sv
// Bench for and3_coinc_filt: default instance (ON=4, OFF=2, W=8) plus a
// boundary instance (ON=1, OFF=1, W=2) sharing the same stimulus.
module tb_and3_coinc_filt;

    logic       CK = 1'b0;
    logic       RSTN = 1'b0, CE = 1'b0, A = 1'b0, B = 1'b0, C = 1'b0, CLR = 1'b0;
    logic       z1, zp1, ovf1, z2, zp2, ovf2;
    logic [7:0] ev1;
    logic [1:0] ev2;

    int checks = 0;
    int errors = 0;

    always #5 CK = ~CK;

    and3_coinc_filt #(.ON_CNT(4), .OFF_CNT(2), .CNT_W(8)) dut (
        .CK(CK), .RSTN(RSTN), .CE(CE), .A(A), .B(B), .C(C), .CLR(CLR),
        .Z(z1), .ZP(zp1), .EVCNT(ev1), .OVF(ovf1)
    );

    and3_coinc_filt #(.ON_CNT(1), .OFF_CNT(1), .CNT_W(2)) dut2 (
        .CK(CK), .RSTN(RSTN), .CE(CE), .A(A), .B(B), .C(C), .CLR(CLR),
        .Z(z2), .ZP(zp2), .EVCNT(ev2), .OVF(ovf2)
    );

    typedef struct {
        bit rstn, ce, a, b, c, clr;
        bit z, zp;
        int ev;
    } vec_t;

    vec_t tbl[$];

    // Reference model: history of enabled samples per instance.
    bit q0[$];
    bit q1[$];
    bit mz[2], mzp[2], movf[2];
    int mev[2];
    int on_m[2]  = '{4, 1};
    int off_m[2] = '{2, 1};
    int max_m[2] = '{255, 3};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit rstn, input bit ce, input bit a, input bit b, input bit c, input bit clr);
        RSTN = rstn; CE = ce; A = a; B = b; C = c; CLR = clr;
        @(posedge CK);
        #1;
    endtask

    task automatic add(input bit rstn, input bit ce, input bit a, input bit b, input bit c,
                       input bit clr, input bit z, input bit zp, input int ev);
        vec_t v;
        v = '{rstn, ce, a, b, c, clr, z, zp, ev};
        tbl.push_back(v);
    endtask

    function automatic bit trail(input bit q[$], input int n, input bit v);
        if (q.size() < n) return 1'b0;
        for (int k = 0; k < n; k++)
            if (q[q.size() - 1 - k] != v) return 1'b0;
        return 1'b1;
    endfunction

    task automatic model_step(input int i, input bit rstn, input bit ce, input bit x, input bit clr);
        bit q[$];
        bit r;
        if (i == 0) q = q0; else q = q1;
        r = 1'b0;
        if (!rstn) begin
            q.delete();
            mz[i] = 0; mzp[i] = 0; mev[i] = 0; movf[i] = 0;
        end else begin
            if (ce) begin
                q.push_back(x);
                if (q.size() > 300) void'(q.pop_front());
                if (!mz[i] && trail(q, on_m[i], 1'b1)) begin
                    mz[i] = 1; r = 1'b1;
                end else if (mz[i] && trail(q, off_m[i], 1'b0)) begin
                    mz[i] = 0;
                end
            end
            mzp[i] = r;
            if (clr) begin
                mev[i] = 0; movf[i] = 0;
            end else if (r) begin
                if (mev[i] == max_m[i]) movf[i] = 1; else mev[i]++;
            end
        end
        if (i == 0) q0 = q; else q1 = q;
    endtask

    initial begin
        int exp_ev[5] = '{1, 2, 3, 3, 3};

        // rstn ce a b c clr | z zp ev  (default instance)
        add(0,1,1,1,1,0, 0,0,0);
        add(1,1,1,1,1,0, 0,0,0);
        add(1,1,1,1,1,0, 0,0,0);
        add(1,1,1,1,1,0, 0,0,0);
        add(1,1,1,1,1,0, 1,1,1);
        add(1,1,1,1,1,0, 1,0,1);
        add(1,1,1,1,0,0, 1,0,1);   // one miss: releasing
        add(1,1,1,1,1,0, 1,0,1);   // back to active, no pulse
        add(1,1,0,1,1,0, 1,0,1);
        add(1,1,1,0,1,0, 0,0,1);   // second miss: release
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,0,0,0,0, 0,0,1);   // break after 3 highs
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,1,1,1,0, 0,0,1);
        add(1,1,1,1,1,0, 1,1,2);
        add(1,1,0,0,0,0, 1,0,2);
        add(1,1,0,0,0,0, 0,0,2);
        add(1,1,1,1,1,0, 0,0,2);   // CE toggling with x=1
        add(1,0,1,1,1,0, 0,0,2);
        add(1,1,1,1,1,0, 0,0,2);
        add(1,0,1,1,1,0, 0,0,2);
        add(1,1,1,1,1,0, 0,0,2);
        add(1,0,1,1,1,0, 0,0,2);
        add(1,1,1,1,1,0, 1,1,3);   // 7th edge, 4th enabled
        add(1,0,1,1,1,0, 1,0,3);
        add(1,0,0,0,0,0, 1,0,3);   // disabled lows do not release
        add(1,0,0,0,0,0, 1,0,3);
        add(1,0,0,0,0,1, 1,0,0);   // clear works with CE low
        add(1,1,0,0,0,0, 1,0,0);
        add(1,1,0,0,0,0, 0,0,0);

        foreach (tbl[i]) begin
            step(tbl[i].rstn, tbl[i].ce, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].clr);
            check($sformatf("tbl%0d_z", i),  int'(z1),  int'(tbl[i].z));
            check($sformatf("tbl%0d_zp", i), int'(zp1), int'(tbl[i].zp));
            check($sformatf("tbl%0d_ev", i), int'(ev1), tbl[i].ev);
        end

        // Saturation on the 2-bit instance (ON=1, OFF=1).
        step(0,1,0,0,0,0);
        check("sat_rst_ev", int'(ev2), 0);
        check("sat_rst_ovf", int'(ovf2), 0);
        for (int k = 0; k < 5; k++) begin
            step(1,1,1,1,1,0);
            check($sformatf("sat%0d_zp", k), int'(zp2), 1);
            check($sformatf("sat%0d_ev", k), int'(ev2), exp_ev[k]);
            check($sformatf("sat%0d_ovf", k), int'(ovf2), (k >= 3) ? 1 : 0);
            step(1,1,0,0,0,0);
            check($sformatf("sat%0d_fall", k), int'(z2), 0);
        end
        step(1,1,0,0,0,1);
        check("clr_ev", int'(ev2), 0);
        check("clr_ovf", int'(ovf2), 0);
        step(1,1,1,1,1,1);
        check("clr_rise_zp", int'(zp2), 1);
        check("clr_rise_ev", int'(ev2), 0);
        step(1,1,1,1,1,0);
        check("clr_after_zp", int'(zp2), 0);
        check("clr_after_ev", int'(ev2), 0);

        // Reset while releasing, default instance.
        step(0,1,0,0,0,0);
        repeat (4) step(1,1,1,1,1,0);
        repeat (2) step(1,1,0,0,0,0);
        repeat (4) step(1,1,1,1,1,0);
        check("rel_ev2", int'(ev1), 2);
        step(1,1,0,0,0,0);
        check("rel_z", int'(z1), 1);
        step(0,1,0,0,0,1);
        check("rst_z", int'(z1), 0);
        check("rst_zp", int'(zp1), 0);
        check("rst_ev", int'(ev1), 0);
        check("rst_ovf", int'(ovf1), 0);
        for (int k = 0; k < 4; k++) begin
            step(1,1,1,1,1,0);
            check($sformatf("rearm%0d_z", k), int'(z1), (k == 3) ? 1 : 0);
        end
        check("rearm_ev", int'(ev1), 1);

        // Randomized run against the reference model, both instances.
        for (int n = 0; n < 1500; n++) begin
            bit rs, ce, a, b, c, cl, hi;
            rs = (n == 0) ? 1'b0 : ($urandom_range(0, 199) != 0);
            ce = ($urandom_range(0, 3) != 0);
            hi = ($urandom_range(0, 2) != 0);
            a  = hi | ($urandom_range(0, 1) == 1);
            b  = hi | ($urandom_range(0, 1) == 1);
            c  = hi & ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 59) == 0);
            model_step(0, rs, ce, a & b & c, cl);
            model_step(1, rs, ce, a & b & c, cl);
            step(rs, ce, a, b, c, cl);
            check("rnd_z1",   int'(z1),   int'(mz[0]));
            check("rnd_zp1",  int'(zp1),  int'(mzp[0]));
            check("rnd_ev1",  int'(ev1),  mev[0]);
            check("rnd_ovf1", int'(ovf1), int'(movf[0]));
            check("rnd_z2",   int'(z2),   int'(mz[1]));
            check("rnd_zp2",  int'(zp2),  int'(mzp[1]));
            check("rnd_ev2",  int'(ev2),  mev[1]);
            check("rnd_ovf2", int'(ovf2), int'(movf[1]));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
